// File: rtl/viterbi_pkg.sv
// Package shared by the Viterbi decoder front-end buffer.
// Holds the default code geometry and the serialiser state encoding.
package viterbi_pkg;

  localparam int WORD_W_DEF = 16;
  localparam int SYM_W_DEF  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO used by viterbi_symbol_buffer to queue received code words.
// Ports:
//   clk        rising-edge clock
//   clr        synchronous clear of pointers and level (reset or flush)
//   push       write wr_data (ignored when full)
//   pop        advance read pointer (ignored when empty)
//   wr_data    word to store
//   rd_data    head-of-queue word (valid when !empty)
//   empty      no words held
//   full_next  FIFO will be full after this edge (used to register in_ready)
//   level      number of words held
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full_next,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_nxt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    case ({do_push, do_pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // A clear cycle never leaves the FIFO full, whatever push/pop say.
  assign full_next = !clr && (level_nxt == LVL_W'(DEPTH));

  // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/viterbi_symbol_buffer.sv
// Front-end buffer of the Viterbi decoder. Queues packed received code words in
// a DEPTH-word FIFO and serialises each into SYM_W-bit code symbols, MSB first,
// one per cycle, for the branch-metric unit.
// Optional feature macro: VITERBI_ERASE_EN (adds erase_in / sym_erase; erased
// bits force the matching sym_out bits to 0).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         synchronous clear, same effect as rst
//   in_valid/in_ready/data_in/in_last   word input handshake
//   sym_valid/sym_ready/sym_out/sym_last symbol output handshake
//   level         words held in FIFO (excludes the word in the serialiser)
module viterbi_symbol_buffer
  import viterbi_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int SYM_W  = SYM_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W-1:0]       data_in,
  input  logic                    in_last,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic [SYM_W-1:0]        sym_out,
  output logic                    sym_last,
`ifdef VITERBI_ERASE_EN
  input  logic [WORD_W-1:0]       erase_in,
  output logic [SYM_W-1:0]        sym_erase,
`endif
  output logic [$clog2(DEPTH):0]  level
);

  localparam int SYMS   = WORD_W / SYM_W;
  localparam int CNT_W  = $clog2(SYMS);
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int CNT_BW = (CNT_W > 0) ? CNT_W : 1;
  localparam logic [CNT_BW-1:0] CNT_MAX = CNT_BW'(SYMS - 1);
`ifdef VITERBI_ERASE_EN
  localparam int FIFO_W = 2 * WORD_W + 1;
`else
  localparam int FIFO_W = WORD_W + 1;
`endif

  if ((WORD_W % SYM_W) != 0) begin : g_chk_word_w
    $error("viterbi_symbol_buffer: WORD_W must be a multiple of SYM_W");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("viterbi_symbol_buffer: DEPTH must be a power of 2 and >= 2");
  end

  logic              clr;
  logic              push;
  logic              pop;
  logic [FIFO_W-1:0] fifo_wr;
  logic [FIFO_W-1:0] fifo_rd;
  logic              fifo_empty;
  logic              fifo_full_next;
  logic              in_ready_q;

  ser_state_t        state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              last_q, last_d;
  logic [CNT_BW-1:0] cnt_q, cnt_d;
`ifdef VITERBI_ERASE_EN
  logic [WORD_W-1:0] erase_q, erase_d;
`endif

  assign clr  = rst || flush;
  assign push = in_valid && in_ready_q;

`ifdef VITERBI_ERASE_EN
  assign fifo_wr = {erase_in, in_last, data_in};
`else
  assign fifo_wr = {in_last, data_in};
`endif

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .pop       (pop),
    .wr_data   (fifo_wr),
    .rd_data   (fifo_rd),
    .empty     (fifo_empty),
    .full_next (fifo_full_next),
    .level     (level)
  );

  // in_ready is registered from the FIFO's next fill state only, so a pop in
  // the same cycle never grants extra credit; it stays low for the clear cycle.
  always_ff @(posedge clk) begin
    if (clr) in_ready_q <= 1'b0;
    else     in_ready_q <= !fifo_full_next;
  end
  assign in_ready = in_ready_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef VITERBI_ERASE_EN
      erase_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
`ifdef VITERBI_ERASE_EN
      erase_q <= erase_d;
`endif
    end
  end

  // Serialiser: loads the FIFO head as soon as it is free, and chains straight
  // into the next word after the final symbol so there is no bubble. Going
  // idle clears the shift state so sym_out/sym_last read 0 while invalid.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
`ifdef VITERBI_ERASE_EN
    erase_d = erase_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd[WORD_W-1:0];
          last_d  = fifo_rd[WORD_W];
          cnt_d   = '0;
`ifdef VITERBI_ERASE_EN
          erase_d = fifo_rd[FIFO_W-1:WORD_W+1];
`endif
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sym_ready) begin
          if (cnt_q != CNT_MAX) begin
            shift_d = shift_q << SYM_W;
            cnt_d   = cnt_q + CNT_BW'(1);
`ifdef VITERBI_ERASE_EN
            erase_d = erase_q << SYM_W;
`endif
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rd[WORD_W-1:0];
            last_d  = fifo_rd[WORD_W];
            cnt_d   = '0;
`ifdef VITERBI_ERASE_EN
            erase_d = fifo_rd[FIFO_W-1:WORD_W+1];
`endif
          end else begin
            shift_d = '0;
            last_d  = 1'b0;
            cnt_d   = '0;
`ifdef VITERBI_ERASE_EN
            erase_d = '0;
`endif
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sym_valid = (state_q == ST_SHIFT);
  assign sym_last  = last_q && (cnt_q == CNT_MAX);
`ifdef VITERBI_ERASE_EN
  assign sym_erase = erase_q[WORD_W-1 -: SYM_W];
  assign sym_out   = shift_q[WORD_W-1 -: SYM_W] & ~erase_q[WORD_W-1 -: SYM_W];
`else
  assign sym_out   = shift_q[WORD_W-1 -: SYM_W];
`endif

  // Keeps LVL_W tied to the level port width for readers of this file.
  if (LVL_W != $bits(level)) begin : g_chk_lvl
    $error("viterbi_symbol_buffer: level width mismatch");
  end

endmodule

// File: tb/tb_viterbi_symbol_buffer.sv
// Self-checking bench for viterbi_symbol_buffer (default build, 16-bit words,
// 2-bit symbols, 4-word FIFO). Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_viterbi_symbol_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic        in_last;
  logic        sym_valid;
  logic        sym_ready;
  logic [1:0]  sym_out;
  logic        sym_last;
  logic [2:0]  level;

  int checks;
  int fails;

  viterbi_symbol_buffer #(
    .WORD_W (16),
    .SYM_W  (2),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .in_last   (in_last),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_out   (sym_out),
    .sym_last  (sym_last),
    .level     (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // MSB-first symbol k of a 16-bit word.
  function automatic logic [1:0] sym_of(input logic [15:0] w, input int k);
    logic [15:0] t;
    t = w << (2 * k);
    return t[15:14];
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; data_in = '0; in_last = 1'b0; sym_ready = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (sym_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_sym_valid: got %b expected 0", sym_valid); end
    checks++;
    if (level !== 3'd0) begin fails++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    checks++;
    if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++;
    if (sym_out !== 2'b00 || sym_last !== 1'b0) begin fails++; $display("[TB] FAIL reset_sym_out: got %b/%b expected 00/0", sym_out, sym_last); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single_word();
    sym_ready = 1'b1;
    in_valid = 1'b1; data_in = 16'hFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (sym_valid !== 1'b0 || level !== 3'd1) begin fails++; $display("[TB] FAIL single_after_push: got valid=%b level=%0d expected valid=0 level=1", sym_valid, level); end
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (sym_valid !== 1'b1 || sym_out !== 2'b11) begin fails++; $display("[TB] FAIL single_sym[%0d]: got valid=%b sym=%b expected valid=1 sym=11", k, sym_valid, sym_out); end
      @(negedge clk);
    end
    checks++;
    if (sym_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_end_valid: got %b expected 0", sym_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_syms [16];
    exp_syms = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b01, 2'b00,
                 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    sym_ready = 1'b1;
    in_valid = 1'b1; data_in = 16'h1234;
    @(negedge clk);
    data_in = 16'hAAAA;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (sym_valid !== 1'b1 || sym_out !== exp_syms[k]) begin fails++; $display("[TB] FAIL b2b_sym[%0d]: got valid=%b sym=%b expected valid=1 sym=%b", k, sym_valid, sym_out, exp_syms[k]); end
      @(negedge clk);
    end
    checks++;
    if (sym_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_end_valid: got %b expected 0", sym_valid); end
  endtask

  task automatic test_fill_and_drain();
    logic [15:0] words [8];
    int accepted;
    int n;
    int cyc;
    words = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'hFEDC, 16'h0F0F, 16'hF0F0, 16'h3C3C};
    sym_ready = 1'b0;
    accepted = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = words[accepted % 8];
      if (!in_ready) break;
      @(negedge clk);
      accepted++;
    end
    in_valid = 1'b0;
    checks++;
    if (accepted !== 5) begin fails++; $display("[TB] FAIL fill_accepted: got %0d expected 5", accepted); end
    checks++;
    if (level !== 3'd4) begin fails++; $display("[TB] FAIL fill_level: got %0d expected 4", level); end
    checks++;
    if (in_ready !== 1'b0 || sym_valid !== 1'b1) begin fails++; $display("[TB] FAIL fill_flags: got in_ready=%b sym_valid=%b expected 0/1", in_ready, sym_valid); end
    sym_ready = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 40 && cyc < 60) begin
      if (sym_valid) begin
        checks++;
        if (sym_out !== sym_of(words[n / 8], n % 8)) begin fails++; $display("[TB] FAIL drain_sym[%0d]: got %b expected %b", n, sym_out, sym_of(words[n / 8], n % 8)); end
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (n !== 40) begin fails++; $display("[TB] FAIL drain_count: got %0d expected 40", n); end
    checks++;
    if (cyc !== 40) begin fails++; $display("[TB] FAIL drain_cycles: got %0d expected 40", cyc); end
    checks++;
    if (sym_valid !== 1'b0 || level !== 3'd0) begin fails++; $display("[TB] FAIL drain_end: got valid=%b level=%0d expected 0/0", sym_valid, level); end
  endtask

  task automatic test_last_and_stall();
    logic [1:0] exp_syms [8];
    exp_syms = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b11, 2'b10, 2'b00};
    sym_ready = 1'b0;
    in_valid = 1'b1; data_in = 16'h5678; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      sym_ready = 1'b0;
      checks++;
      if (sym_valid !== 1'b1 || sym_out !== exp_syms[k] || sym_last !== (k == 7)) begin fails++; $display("[TB] FAIL last_sym[%0d]: got valid=%b sym=%b last=%b expected 1/%b/%b", k, sym_valid, sym_out, sym_last, exp_syms[k], (k == 7)); end
      @(negedge clk);
      checks++;
      if (sym_valid !== 1'b1 || sym_out !== exp_syms[k] || sym_last !== (k == 7)) begin fails++; $display("[TB] FAIL stall_hold[%0d]: got valid=%b sym=%b last=%b expected 1/%b/%b", k, sym_valid, sym_out, sym_last, exp_syms[k], (k == 7)); end
      sym_ready = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (sym_valid !== 1'b0 || sym_last !== 1'b0) begin fails++; $display("[TB] FAIL last_end: got valid=%b last=%b expected 0/0", sym_valid, sym_last); end
  endtask

  task automatic test_mid_word_clear();
    logic [1:0] exp_syms [8];
    exp_syms = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b01, 2'b00};
    for (int mode = 0; mode < 2; mode++) begin
      sym_ready = 1'b1;
      in_valid = 1'b1; data_in = 16'hC3A5;
      @(negedge clk);
      data_in = 16'h0FF0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (sym_valid !== 1'b1 || sym_out !== 2'b11 || level !== 3'd1) begin fails++; $display("[TB] FAIL clear%0d_pre: got valid=%b sym=%b level=%0d expected 1/11/1", mode, sym_valid, sym_out, level); end
      if (mode == 0) flush = 1'b1; else rst = 1'b1;
      @(negedge clk);
      flush = 1'b0; rst = 1'b0;
      checks++;
      if (sym_valid !== 1'b0 || level !== 3'd0 || sym_out !== 2'b00 || in_ready !== 1'b0) begin fails++; $display("[TB] FAIL clear%0d_post: got valid=%b level=%0d sym=%b in_ready=%b expected 0/0/00/0", mode, sym_valid, level, sym_out, in_ready); end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || sym_valid !== 1'b0) begin fails++; $display("[TB] FAIL clear%0d_ready: got in_ready=%b valid=%b expected 1/0", mode, in_ready, sym_valid); end
      in_valid = 1'b1; data_in = 16'h1234;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (sym_valid !== 1'b1 || sym_out !== exp_syms[k]) begin fails++; $display("[TB] FAIL clear%0d_restart[%0d]: got valid=%b sym=%b expected 1/%b", mode, k, sym_valid, sym_out, exp_syms[k]); end
        @(negedge clk);
      end
      checks++;
      if (sym_valid !== 1'b0) begin fails++; $display("[TB] FAIL clear%0d_end: got %b expected 0", mode, sym_valid); end
    end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_fill_and_drain();
    test_last_and_stall();
    test_mid_word_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
